// File: rtl/modbus_rtu_rx_framer_pkg.sv
// Shared types and constants for the Modbus RTU receive framer.
package modbus_rtu_rx_framer_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RECV,
    ST_GAP,
    ST_HOLD
  } rx_state_e;

  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY      = 16'hA001;
  localparam int unsigned MIN_FRAME_LEN = 4;

  // Saturating increment for the 16-bit silence timer and drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/modbus_crc16.sv
// Combinational Modbus CRC-16 byte update (reflected polynomial).
module modbus_crc16
  import modbus_rtu_rx_framer_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  // Eight LSB-first shift/xor steps unrolled into a single cycle.
  always_comb begin
    logic [15:0] c;
    c = crc_i ^ {8'h00, data_i};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer: delimits frames by line silence, buffers the
// bytes, checks length/CRC/address and holds a good frame for a consumer.
module modbus_rtu_rx_framer
  import modbus_rtu_rx_framer_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 256
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  input  logic [15:0] cfg_t15,
  input  logic [15:0] cfg_t35,
  input  logic [7:0]  cfg_slave_addr,
  output logic        frm_valid,
  output logic [8:0]  frm_len,
  output logic        frm_bcast,
  input  logic        frm_ack,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [15:0] stat_drop,
  output logic        stat_ovr
);

  localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);
  localparam int unsigned AW    = $clog2(MAX_BYTES);

  rx_state_e         state_q, state_d;
  logic [15:0]       sil_q, sil_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       crc_q, crc_d;
  logic              bad_q, bad_d;
  logic [7:0]        byte0_q, byte0_d;
  logic              fv_q, fv_d;
  logic [8:0]        len_q, len_d;
  logic              bc_q, bc_d;
  logic [15:0]       drop_q, drop_d;
  logic              ovr_q, ovr_d;
  logic              hrx_q, hrx_d;
  logic [7:0]        rd_q;

  logic [7:0]        mem_q [MAX_BYTES];
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [15:0]       crc_seed;
  logic [15:0]       crc_nxt;
  logic              frame_good;

  // The first byte of a frame starts from the CRC seed instead of the register.
  assign crc_seed = (state_q == ST_IDLE) ? CRC_INIT : crc_q;

  modbus_crc16 u_crc (
    .crc_i  (crc_seed),
    .data_i (rx_data),
    .crc_o  (crc_nxt)
  );

  assign frame_good = !bad_q
                   && (cnt_q >= CNT_W'(MIN_FRAME_LEN))
                   && (cnt_q <= CNT_W'(MAX_BYTES))
                   && (crc_q == 16'h0000)
                   && ((byte0_q == cfg_slave_addr) || (byte0_q == 8'h00));

  // Next-state and datapath updates; an incoming byte takes priority over timeouts.
  always_comb begin
    state_d = state_q;
    sil_d   = rx_valid ? '0 : sat_inc16(sil_q);
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    bad_d   = bad_q;
    byte0_d = byte0_q;
    fv_d    = fv_q;
    len_d   = len_q;
    bc_d    = bc_q;
    drop_d  = drop_q;
    ovr_d   = ovr_q;
    hrx_d   = hrx_q;
    wr_en   = 1'b0;
    wr_idx  = '0;

    case (state_q)
      ST_INIT: begin
        if (!rx_valid && (sil_q >= cfg_t35)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rx_valid) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          crc_d   = crc_nxt;
          cnt_d   = CNT_W'(1);
          bad_d   = rx_err;
          byte0_d = rx_data;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          if (cnt_q == CNT_W'(MAX_BYTES)) begin
            bad_d = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_idx = AW'(cnt_q);
            cnt_d  = cnt_q + CNT_W'(1);
            crc_d  = crc_nxt;
            bad_d  = bad_q | rx_err;
          end
        end else if (sil_q >= cfg_t15) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (rx_valid) begin
          bad_d = 1'b1;
        end else if (sil_q >= cfg_t35) begin
          if (frame_good) begin
            fv_d    = 1'b1;
            len_d   = 9'(cnt_q - CNT_W'(2));
            bc_d    = (byte0_q == 8'h00);
            hrx_d   = 1'b0;
            state_d = ST_HOLD;
          end else begin
            drop_d  = sat_inc16(drop_q);
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (rx_valid) begin
          ovr_d = 1'b1;
          hrx_d = 1'b1;
        end
        // A byte in the release cycle counts as arriving during the hold.
        if (frm_ack) begin
          fv_d    = 1'b0;
          state_d = (hrx_q || rx_valid) ? ST_INIT : ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_INIT;
      sil_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
      bad_q   <= 1'b0;
      byte0_q <= '0;
      fv_q    <= 1'b0;
      len_q   <= '0;
      bc_q    <= 1'b0;
      drop_q  <= '0;
      ovr_q   <= 1'b0;
      hrx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sil_q   <= sil_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      bad_q   <= bad_d;
      byte0_q <= byte0_d;
      fv_q    <= fv_d;
      len_q   <= len_d;
      bc_q    <= bc_d;
      drop_q  <= drop_d;
      ovr_q   <= ovr_d;
      hrx_q   <= hrx_d;
    end
  end

  // Frame buffer writes; contents deliberately survive reset.
  always_ff @(posedge PCLK) begin
    if (wr_en && !PRESET) mem_q[wr_idx] <= rx_data;
  end

  // Registered read port, available in every state.
  always_ff @(posedge PCLK) begin
    if (PRESET) rd_q <= '0;
    else        rd_q <= mem_q[AW'(rd_addr)];
  end

  assign frm_valid = fv_q;
  assign frm_len   = len_q;
  assign frm_bcast = bc_q;
  assign stat_drop = drop_q;
  assign stat_ovr  = ovr_q;
  assign rd_data   = rd_q;

endmodule

// File: tb/tb_modbus_rtu_rx_framer.sv
// Directed self-checking bench for modbus_rtu_rx_framer.
module tb_modbus_rtu_rx_framer;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_err;
  logic [15:0] cfg_t15;
  logic [15:0] cfg_t35;
  logic [7:0]  cfg_slave_addr;
  logic        frm_valid;
  logic [8:0]  frm_len;
  logic        frm_bcast;
  logic        frm_ack;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [15:0] stat_drop;
  logic        stat_ovr;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] good_frm [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};

  modbus_rtu_rx_framer #(.MAX_BYTES(256)) dut (
    .PCLK           (PCLK),
    .PRESET         (PRESET),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_err         (rx_err),
    .cfg_t15        (cfg_t15),
    .cfg_t35        (cfg_t35),
    .cfg_slave_addr (cfg_slave_addr),
    .frm_valid      (frm_valid),
    .frm_len        (frm_len),
    .frm_bcast      (frm_bcast),
    .frm_ack        (frm_ack),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .stat_drop      (stat_drop),
    .stat_ovr       (stat_ovr)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One byte strobe followed by 9 quiet cycles (10-cycle spacing).
  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_err   = e;
    tick();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    idle(9);
  endtask

  task automatic send_frame(input int nbytes, input logic [7:0] last,
                            input int err_at, input int gap_after);
    for (int i = 0; i < nbytes; i++) begin
      send_byte((i == 7) ? last : good_frm[i], i == err_at);
      if (i == gap_after) idle(10);
    end
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic ack();
    frm_ack = 1'b1;
    tick();
    frm_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    PRESET = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_err = 1'b0;
    cfg_t15 = 16'd15; cfg_t35 = 16'd35; cfg_slave_addr = 8'h01;
    frm_ack = 1'b0; rd_addr = '0;
    idle(2);
    chk("rst_valid", 32'(frm_valid), 0);
    chk("rst_len",   32'(frm_len),   0);
    chk("rst_bcast", 32'(frm_bcast), 0);
    chk("rst_drop",  32'(stat_drop), 0);
    chk("rst_ovr",   32'(stat_ovr),  0);
    chk("rst_rd",    32'(rd_data),   0);
    PRESET = 1'b0;
    idle(40);

    // Good addressed frame.
    send_frame(8, 8'hCD, -1, -1);
    idle(40);
    chk("good_valid", 32'(frm_valid), 1);
    chk("good_len",   32'(frm_len),   6);
    chk("good_bcast", 32'(frm_bcast), 0);
    for (int i = 0; i < 6; i++) rd_chk(8'(i), good_frm[i], $sformatf("good_rd%0d", i));
    ack();
    chk("ack_valid", 32'(frm_valid), 0);
    idle(5);

    // CRC error.
    send_frame(8, 8'hCE, -1, -1);
    idle(40);
    chk("crc_valid", 32'(frm_valid), 0);
    chk("crc_drop",  32'(stat_drop), 1);

    // t1.5 violation after byte 3.
    send_frame(8, 8'hCD, -1, 2);
    idle(40);
    chk("gap_valid", 32'(frm_valid), 0);
    chk("gap_drop",  32'(stat_drop), 2);

    // Line error on one byte.
    send_frame(8, 8'hCD, 2, -1);
    idle(40);
    chk("err_valid", 32'(frm_valid), 0);
    chk("err_drop",  32'(stat_drop), 3);

    // Byte during HOLD, then release into INIT.
    send_frame(8, 8'hCD, -1, -1);
    idle(40);
    chk("hold_valid", 32'(frm_valid), 1);
    send_byte(8'h55, 1'b0);
    chk("hold_ovr",   32'(stat_ovr),  1);
    chk("hold_still", 32'(frm_valid), 1);
    ack();
    chk("hold_ack", 32'(frm_valid), 0);
    send_frame(8, 8'hCD, -1, -1);
    idle(40);
    chk("init_ignored", 32'(frm_valid), 0);
    chk("init_nodrop",  32'(stat_drop), 3);
    send_frame(8, 8'hCD, -1, -1);
    idle(40);
    chk("after_init_valid", 32'(frm_valid), 1);
    chk("after_init_len",   32'(frm_len),   6);
    ack();
    idle(5);

    // 258 back-to-back bytes: overflow, no wrap.
    for (int i = 0; i < 258; i++) begin
      rx_valid = 1'b1;
      rx_data  = (i == 256) ? 8'hEE : (i == 257) ? 8'hEF : 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    idle(45);
    chk("ovf_valid", 32'(frm_valid), 0);
    chk("ovf_drop",  32'(stat_drop), 4);
    rd_chk(8'd255, 8'hFF, "ovf_rd255");
    rd_chk(8'd0,   8'h00, "ovf_rd0");
    rd_chk(8'd1,   8'h01, "ovf_rd1");

    // Reset mid-frame after byte 4.
    send_frame(4, 8'hCD, -1, -1);
    PRESET = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(frm_valid), 0);
    chk("mid_rst_len",   32'(frm_len),   0);
    chk("mid_rst_bcast", 32'(frm_bcast), 0);
    chk("mid_rst_drop",  32'(stat_drop), 0);
    chk("mid_rst_ovr",   32'(stat_ovr),  0);
    chk("mid_rst_rd",    32'(rd_data),   0);
    PRESET = 1'b0;
    tick();
    chk("mid_rst_buf_kept", 32'(rd_data), 32'h03);
    idle(40);
    chk("mid_rst_drop_after", 32'(stat_drop), 0);
    send_frame(8, 8'hCD, -1, -1);
    idle(40);
    chk("post_rst_valid", 32'(frm_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
